// File: rtl/mw_pkg.sv
// Shared types and constants for the microwave controller: FSM states,
// BCD digit width and 7-segment (gfedcba, active-high) glyphs.
package mw_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } mw_state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to 7-segment decoder; codes above 9 blank the digit.
module bcd_to_7seg
  import mw_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mw_controller_gen.sv
// Microwave controller: keypad entry, mm:ss BCD countdown, power duty cycle,
// door interlock, pause/resume, quick start and latched done.
module mw_controller_gen
  import mw_pkg::*;
#(
  parameter int TICK_DIV     = 100,
  parameter int DIGITS       = 4,
  parameter int POWER_PERIOD = 10,
  parameter int QUICK_SECS   = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    door_closed,
  input  logic                    key_valid,
  input  logic [3:0]              key_digit,
  input  logic                    power_set,
  input  logic [3:0]              power_level,
  output logic                    mag_on,
  output logic                    running,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] time_bcd,
  output logic [7*DIGITS-1:0]     segs
);

  localparam int TW = BCD_W * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] QUICK_BCD = TW'((QUICK_SECS / 10) * 16 + (QUICK_SECS % 10));
  localparam logic [TW-1:0] ONE_SEC   = TW'(1);
  localparam logic [3:0]    PWR_MAX   = 4'(POWER_PERIOD);
  localparam logic [3:0]    PHASE_TOP = 4'(POWER_PERIOD - 1);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  mw_state_e     state_q, state_d;
  logic [TW-1:0] time_q, time_d;
  logic [3:0]    power_q, power_d;
  logic [3:0]    phase_q, phase_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mag_q, mag_d;

  logic          tick;
  logic          key_ok;
  logic [3:0]    power_clamped;
  logic [TW-1:0] time_shift;
  logic [TW-1:0] time_dec;
  logic [DIGITS-1:0] borrow;

  assign tick          = (state_q == ST_RUN) && (presc_q == PRESC_TOP);
  assign key_ok        = key_valid && (key_digit <= 4'd9);
  assign power_clamped = (power_level > PWR_MAX) ? PWR_MAX : power_level;
  assign time_shift    = {time_q[TW-BCD_W-1:0], key_digit};

  // Ripple-borrow BCD decrement; the seconds-tens digit wraps to 5, all others to 9.
  assign borrow[0] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
    localparam logic [3:0] WRAP = (gi == 1) ? 4'd5 : 4'd9;
    logic [3:0] dig;
    assign dig = time_q[gi*BCD_W +: BCD_W];
    assign time_dec[gi*BCD_W +: BCD_W] = !borrow[gi] ? dig :
                                         ((dig == 4'd0) ? WRAP : dig - 4'd1);
    if (gi < DIGITS - 1) begin : g_borrow
      assign borrow[gi+1] = borrow[gi] && (dig == 4'd0);
    end
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    power_d = power_q;
    phase_d = phase_q;
    presc_d = '0;
    if (clear) begin
      state_d = ST_IDLE;
      time_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stop) begin
            time_d = '0;
          end else if (start) begin
            if (door_closed) begin
              state_d = ST_RUN;
              phase_d = '0;
              if (time_q == '0) time_d = QUICK_BCD;
            end
          end else begin
            if (key_ok)    time_d  = time_shift;
            if (power_set) power_d = power_clamped;
          end
        end
        ST_RUN: begin
          if (stop || !door_closed) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            phase_d = (phase_q == PHASE_TOP) ? 4'd0 : phase_q + 4'd1;
            if (time_q == ONE_SEC) begin
              time_d  = '0;
              state_d = ST_DONE;
            end else begin
              time_d = time_dec;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            state_d = ST_IDLE;
            time_d  = '0;
          end else if (start) begin
            if (door_closed) state_d = ST_RUN;
          end else if (power_set) begin
            power_d = power_clamped;
          end
        end
        ST_DONE: begin
          if (start || stop) begin
            state_d = ST_IDLE;
          end else if (key_ok) begin
            state_d = ST_IDLE;
            time_d  = time_shift;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Registered from next-state so mag_q lines up with state_q and phase_q.
    mag_d = (state_d == ST_RUN) && door_closed && (phase_d < power_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      power_q <= PWR_MAX;
      phase_q <= '0;
      presc_q <= '0;
      mag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      power_q <= power_d;
      phase_q <= phase_d;
      presc_q <= presc_d;
      mag_q   <= mag_d;
    end
  end

  // Door interlock also gates the output combinationally for a same-cycle drop.
  assign mag_on   = mag_q && door_closed;
  assign running  = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign time_bcd = time_q;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
    bcd_to_7seg u_seg (
      .bcd (time_q[gi*BCD_W +: BCD_W]),
      .seg (segs[gi*7 +: 7])
    );
  end

endmodule

// File: tb/tb_mw_controller_gen.sv
// Bench for mw_controller_gen: directed scenarios plus random traffic, every
// cycle compared against a seconds/minutes arithmetic model of the oven.
module tb_mw_controller_gen;

  localparam int TD = 4;
  localparam int DG = 4;
  localparam int PP = 10;
  localparam int QS = 30;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic            clk = 1'b0;
  logic            rst, start, stop, clear, door_closed, key_valid, power_set;
  logic [3:0]      key_digit, power_level;
  logic            mag_on, running, done;
  logic [4*DG-1:0] time_bcd;
  logic [7*DG-1:0] segs;

  mw_controller_gen #(
    .TICK_DIV     (TD),
    .DIGITS       (DG),
    .POWER_PERIOD (PP),
    .QUICK_SECS   (QS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .door_closed (door_closed),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .power_set   (power_set),
    .power_level (power_level),
    .mag_on      (mag_on),
    .running     (running),
    .done        (done),
    .time_bcd    (time_bcd),
    .segs        (segs)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: digits as integers, time handled as seconds/minutes values.
  int m_st, m_pow, m_presc, m_phase;
  int m_d[DG];

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic bit m_zero();
    for (int i = 0; i < DG; i++) if (m_d[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_one_sec();
    for (int i = 1; i < DG; i++) if (m_d[i] != 0) return 1'b0;
    return m_d[0] == 1;
  endfunction

  task automatic m_clear_time();
    for (int i = 0; i < DG; i++) m_d[i] = 0;
  endtask

  task automatic m_shift(input int k);
    for (int i = DG - 1; i > 0; i--) m_d[i] = m_d[i-1];
    m_d[0] = k;
  endtask

  task automatic m_decrement();
    int secs, mins;
    secs = m_d[1] * 10 + m_d[0];
    if (secs > 0) begin
      secs--;
    end else begin
      secs = 59;
      mins = 0;
      for (int i = DG - 1; i >= 2; i--) mins = mins * 10 + m_d[i];
      mins--;
      for (int i = 2; i < DG; i++) begin
        m_d[i] = mins % 10;
        mins   = mins / 10;
      end
    end
    m_d[0] = secs % 10;
    m_d[1] = secs / 10;
  endtask

  task automatic m_reset();
    m_st = M_IDLE; m_pow = PP; m_presc = 0; m_phase = 0;
    m_clear_time();
  endtask

  task automatic m_step();
    bit kok;
    int lvl;
    kok = key_valid && (key_digit <= 4'd9);
    lvl = (int'(power_level) > PP) ? PP : int'(power_level);
    if (clear) begin
      m_st = M_IDLE; m_clear_time(); m_presc = 0;
    end else begin
      case (m_st)
        M_IDLE: begin
          if (stop) m_clear_time();
          else if (start) begin
            if (door_closed) begin
              if (m_zero()) begin m_d[1] = QS / 10; m_d[0] = QS % 10; end
              m_st = M_RUN; m_presc = 0; m_phase = 0;
            end
          end else begin
            if (kok) m_shift(int'(key_digit));
            if (power_set) m_pow = lvl;
          end
        end
        M_RUN: begin
          if (stop || !door_closed) begin
            m_st = M_PAUSE; m_presc = 0;
          end else if (m_presc == TD - 1) begin
            m_presc = 0;
            m_phase = (m_phase + 1) % PP;
            if (m_one_sec()) begin m_clear_time(); m_st = M_DONE; end
            else m_decrement();
          end else begin
            m_presc++;
          end
        end
        M_PAUSE: begin
          if (stop) begin m_st = M_IDLE; m_clear_time(); end
          else if (start) begin
            if (door_closed) begin m_st = M_RUN; m_presc = 0; end
          end else if (power_set) m_pow = lvl;
        end
        default: begin
          if (start || stop) m_st = M_IDLE;
          else if (kok) begin m_st = M_IDLE; m_shift(int'(key_digit)); end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    logic [4*DG-1:0] et;
    logic [7*DG-1:0] es;
    for (int i = 0; i < DG; i++) begin
      et[4*i +: 4] = 4'(m_d[i]);
      es[7*i +: 7] = seg_of(m_d[i]);
    end
    check("time_bcd", 64'(time_bcd), 64'(et));
    check("segs", 64'(segs), 64'(es));
    check("running", 64'(running), 64'(m_st == M_RUN));
    check("done", 64'(done), 64'(m_st == M_DONE));
    check("mag_on", 64'(mag_on), 64'((m_st == M_RUN) && door_closed && (m_phase < m_pow)));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) m_reset();
    else m_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse(input bit s, input bit p, input bit c, input bit kv,
                       input logic [3:0] kd, input bit ps, input logic [3:0] pl);
    start = s; stop = p; clear = c; key_valid = kv; key_digit = kd;
    power_set = ps; power_level = pl;
    cycle();
    start = 1'b0; stop = 1'b0; clear = 1'b0; key_valid = 1'b0; power_set = 1'b0;
  endtask

  task automatic key(input int d);
    pulse(0, 0, 0, 1, 4'(d), 0, 4'd0);
  endtask

  logic [7*DG-1:0] seg_zero;
  int hi_cnt;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; door_closed = 1'b1;
    key_valid = 1'b0; key_digit = 4'd0; power_set = 1'b0; power_level = 4'd0;
    seg_zero = {DG{7'h3F}};
    m_reset();
    run(2);
    rst = 1'b0;
    check("reset_time", 64'(time_bcd), 64'h0);
    check("reset_segs", 64'(segs), 64'(seg_zero));
    check("reset_mag", 64'(mag_on), 64'h0);

    // 1: keyed entry and minute borrow
    key(1); key(0); key(5);
    check("t1_entry", 64'(time_bcd), 64'h0105);
    pulse(1, 0, 0, 0, 4'd0, 0, 4'd0);
    run(TD);
    check("t1_first_tick", 64'(time_bcd), 64'h0104);
    run(5 * TD);
    check("t1_borrow", 64'(time_bcd), 64'h0059);
    check("t1_mag", 64'(mag_on), 64'h1);
    pulse(0, 0, 1, 0, 4'd0, 0, 4'd0);

    // 2: quick start to done, key exits done
    pulse(1, 0, 0, 0, 4'd0, 0, 4'd0);
    check("t2_quick", 64'(time_bcd), 64'h0030);
    run(QS * TD);
    check("t2_done", 64'(done), 64'h1);
    check("t2_mag_off", 64'(mag_on), 64'h0);
    key(7);
    check("t2_key_exit", 64'(time_bcd), 64'h0007);

    // 3: door open pauses, start with door open ignored, resume timing
    pulse(0, 0, 1, 0, 4'd0, 0, 4'd0);
    key(1); key(0);
    pulse(1, 0, 0, 0, 4'd0, 0, 4'd0);
    run(3 * TD);
    check("t3_held_pre", 64'(time_bcd), 64'h0007);
    check("t3_mag_pre", 64'(mag_on), 64'h1);
    door_closed = 1'b0;
    #1;
    check("t3_mag_same_cycle", 64'(mag_on), 64'h0);
    cycle();
    pulse(1, 0, 0, 0, 4'd0, 0, 4'd0);
    check("t3_open_start", 64'(running), 64'h0);
    door_closed = 1'b1;
    pulse(1, 0, 0, 0, 4'd0, 0, 4'd0);
    run(TD - 1);
    check("t3_resume_hold", 64'(time_bcd), 64'h0007);
    run(1);
    check("t3_resume_dec", 64'(time_bcd), 64'h0006);

    // 4: power 3 of 10
    pulse(0, 0, 1, 0, 4'd0, 0, 4'd0);
    pulse(0, 0, 0, 0, 4'd0, 1, 4'd3);
    key(2); key(0);
    pulse(1, 0, 0, 0, 4'd0, 0, 4'd0);
    hi_cnt = 0;
    for (int i = 0; i < PP * TD; i++) begin
      cycle();
      if (mag_on) hi_cnt++;
    end
    check("t4_duty_cycles", 64'(hi_cnt), 64'(3 * TD));
    run(PP * TD);
    check("t4_done", 64'(done), 64'h1);

    // 5: priority and stop from pause
    key(5);
    pulse(1, 0, 0, 0, 4'd0, 0, 4'd0);
    run(2);
    pulse(1, 1, 1, 0, 4'd0, 0, 4'd0);
    check("t5_all_cmds", 64'({running, time_bcd}), 64'h0);
    key(9);
    pulse(1, 0, 0, 0, 4'd0, 0, 4'd0);
    run(2);
    pulse(0, 1, 0, 0, 4'd0, 0, 4'd0);
    pulse(0, 1, 0, 0, 4'd0, 0, 4'd0);
    check("t5_pause_stop", 64'(time_bcd), 64'h0);

    // 6: reset mid-run, invalid key
    key(1); key(2);
    pulse(1, 0, 0, 0, 4'd0, 0, 4'd0);
    run(5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_mag", 64'(mag_on), 64'h0);
    check("t6_segs", 64'(segs), 64'(seg_zero));
    key(11);
    check("t6_bad_key", 64'(time_bcd), 64'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 4) door_closed = ~door_closed;
      rst = ($urandom_range(999) < 2);
      start = ($urandom_range(99) < 8);
      stop  = ($urandom_range(99) < 3);
      clear = ($urandom_range(99) < 2);
      if (!start && !stop && !clear) begin
        key_valid   = ($urandom_range(99) < 15);
        key_digit   = 4'($urandom_range(15));
        power_set   = ($urandom_range(99) < 8);
        power_level = 4'($urandom_range(15));
      end
      cycle();
      rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
      key_valid = 1'b0; power_set = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
